// File: rtl/pipe_arith_pkg.sv
// Shared definitions for the pipelined chunked arithmetic blocks.
//   stage_sb_t   : side-band that travels with each transaction through the
//                  stage registers (valid, subtract flag, saturate flag, carry)
//   chunk_width  : per-stage chunk width for an M-bit datapath split STAGES ways
//   cfg_ok       : legality of an (M, STAGES) pair, checked at elaboration
package pipe_arith_pkg;

  typedef struct packed {
    logic valid;
    logic sub;
    logic sat;
    logic carry;
  } stage_sb_t;

  function automatic int chunk_width(input int m, input int stages);
    return m / stages;
  endfunction

  function automatic bit cfg_ok(input int m, input int stages);
    int cw;
    if (stages < 1 || stages > m / 4 || m % stages != 0) return 1'b0;
    cw = m / stages;
    return (cw == 4) || (cw == 8) || (cw == 16) || (cw == 32);
  endfunction

endpackage

// File: rtl/cla_add_sub.sv
// Generic W-bit carry-lookahead adder-subtractor (parallel-prefix carries).
//   a, b   : operands
//   sub    : 1 = a - b (b inverted, carry-in inverted)
//   cin    : carry-in
//   s      : sum/difference
//   cout   : carry out of bit W-1
//   c_msb  : carry into bit W-1 (for signed overflow)
module cla_add_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W-1:0] bb, g, p, gk, pk, gn, pn, c;
  logic         ci;

  // Kogge-Stone prefix: after the loop gk[i] is the group generate of
  // bits [i:0] with the carry-in folded into bit 0, i.e. the carry into i+1.
  always_comb begin
    bb = b ^ {W{sub}};
    ci = cin ^ sub;
    g  = a & bb;
    p  = a ^ bb;
    gk = g;
    pk = p;
    gk[0] = g[0] | (p[0] & ci);
    for (int d = 1; d < W; d = d * 2) begin
      gn = gk;
      pn = pk;
      for (int i = d; i < W; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i-d]);
        pn[i] = pk[i] & pk[i-d];
      end
      gk = gn;
      pk = pn;
    end
    c     = {gk[W-2:0], ci};
    s     = p ^ c;
    cout  = gk[W-1];
    c_msb = c[W-1];
  end

endmodule

// File: rtl/pipe_cla_stage.sv
// One pipeline stage of the chunked adder: CW-bit CLA chunk add plus the
// stage register for the chunk sum and the side-band.
//   adv    : pipeline advance enable
//   a, b   : aligned operand chunks (b already conditionally inverted)
//   sb_in  : incoming side-band; sb_in.carry is this chunk's carry-in
//   sb_q   : registered side-band; sb_q.carry is this chunk's carry-out
//   sum_q  : registered chunk sum
//   c_msb  : combinational carry into the chunk MSB (overflow detection)
module pipe_cla_stage import pipe_arith_pkg::*; #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  stage_sb_t     sb_in,
  output stage_sb_t     sb_q,
  output logic [CW-1:0] sum_q,
  output logic          c_msb
);

  logic [CW-1:0] sum;
  logic          c_out;

  cla_add_sub #(.W(CW)) u_cla (
    .a(a), .b(b), .sub(1'b0), .cin(sb_in.carry),
    .s(sum), .cout(c_out), .c_msb(c_msb)
  );

  // Payload only loads for real transactions so bubbles leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q  <= '0;
      sum_q <= '0;
    end else if (adv) begin
      sb_q.valid <= sb_in.valid;
      if (sb_in.valid) begin
        sb_q.sub   <= sb_in.sub;
        sb_q.sat   <= sb_in.sat;
        sb_q.carry <= c_out;
        sum_q      <= sum;
      end
    end
  end

endmodule

// File: rtl/pipe_cla_add_sub.sv
// Pipelined two's-complement adder-subtractor with valid/ready handshake.
// The M-bit add is cut into STAGES chunks of CW bits; chunk k is added in
// stage k. Operand chunks are skewed by k registers, chunk results de-skewed
// by STAGES-1-k registers, so every result sees exactly STAGES registers.
// Optional macro PIPE_ADD_SUB_SAT_EN adds input sat (signed saturation).
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (in_ready = advance)
//   sub, cin, x, y       : op select (1 = x - y), carry-in, operands
//   out_valid / out_ready: result handshake
//   out, cout, v         : result, carry/borrow-out, signed overflow
module pipe_cla_add_sub import pipe_arith_pkg::*; #(
  parameter int M      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic         cin,
`ifdef PIPE_ADD_SUB_SAT_EN
  input  logic         sat,
`endif
  input  logic [M-1:0] x,
  input  logic [M-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out,
  output logic         cout,
  output logic         v
);

  localparam int CW = chunk_width(M, STAGES);

  if (!cfg_ok(M, STAGES)) begin : g_bad_cfg
    $error("pipe_cla_add_sub: M must split into STAGES chunks of 4/8/16/32 bits");
  end

  logic                       adv, sat_in, sat_hit, msb_cq, xmsb_q;
  logic [M-1:0]               yi;
  stage_sb_t [STAGES:0]       sb_pipe;
  logic [STAGES:0]            vld_pipe;
  logic [STAGES-1:0][CW-1:0]  res;

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

`ifdef PIPE_ADD_SUB_SAT_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  assign yi         = y ^ {M{sub}};
  assign sb_pipe[0] = '{valid: in_valid, sub: sub, sat: sat_in, carry: cin ^ sub};

  for (genvar k = 0; k <= STAGES; k++) begin : g_vld
    assign vld_pipe[k] = sb_pipe[k].valid;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    localparam int D = STAGES - 1 - k;
    logic [CW-1:0] xa, ya, sum_q;
    logic          cm;

    // Operand skew: level j loads alongside the transaction at depth j.
    if (k == 0) begin : g_noskew
      assign xa = x[CW-1:0];
      assign ya = yi[CW-1:0];
    end else begin : g_skew
      logic [k-1:0][CW-1:0] xr, yr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          xr <= '0;
          yr <= '0;
        end else begin
          if (adv & vld_pipe[0]) begin
            xr[0] <= x[k*CW +: CW];
            yr[0] <= yi[k*CW +: CW];
          end
          for (int j = 1; j < k; j++)
            if (adv & vld_pipe[j]) begin
              xr[j] <= xr[j-1];
              yr[j] <= yr[j-1];
            end
        end
      end
      assign xa = xr[k-1];
      assign ya = yr[k-1];
    end

    pipe_cla_stage #(.CW(CW)) u_stage (
      .clk(clk), .rst_n(rst_n), .adv(adv),
      .a(xa), .b(ya),
      .sb_in(sb_pipe[k]), .sb_q(sb_pipe[k+1]),
      .sum_q(sum_q), .c_msb(cm)
    );

    // Result de-skew: the last level loads with the final stage so out
    // holds across bubbles together with cout/v.
    if (D == 0) begin : g_nodsk
      assign res[k] = sum_q;
    end else begin : g_dsk
      logic [D-1:0][CW-1:0] dr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dr <= '0;
        end else begin
          if (adv & vld_pipe[k+1]) dr[0] <= sum_q;
          for (int j = 1; j < D; j++)
            if (adv & vld_pipe[k+1+j]) dr[j] <= dr[j-1];
        end
      end
      assign res[k] = dr[D-1];
    end

    // Top chunk also captures the MSB carry-in and x sign for v/saturation.
    if (k == STAGES - 1) begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          msb_cq <= 1'b0;
          xmsb_q <= 1'b0;
        end else if (adv & vld_pipe[k]) begin
          msb_cq <= cm;
          xmsb_q <= xa[CW-1];
        end
      end
    end else begin : g_mid
      logic unused_cm;
      assign unused_cm = cm;
    end
  end

  assign cout    = sb_pipe[STAGES].carry ^ sb_pipe[STAGES].sub;
  assign v       = msb_cq ^ sb_pipe[STAGES].carry;
  assign sat_hit = sb_pipe[STAGES].sat & v;
  assign out     = sat_hit ? (xmsb_q ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}})
                           : res;

endmodule

// File: tb/tb_pipe_cla_add_sub.sv
// Directed bench for pipe_cla_add_sub: a 4-stage instance (main checks) and a
// 1-stage instance sharing the same stimulus (single-cycle latency checks).
module tb_pipe_cla_add_sub;
  localparam int M = 32;

  typedef struct packed {
    logic        sub;
    logic        cin;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    logic        co;
    logic        ov;
  } vec_t;

  // Hand-computed vectors: {sub, cin, x, y, result, cout, v}
  vec_t vt [16] = '{
    '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0},
    '{1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0},
    '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0},
    '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0},
    '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0},
    '{1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1},
    '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1},
    '{1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1},
    '{1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0},
    '{1'b1, 1'b0, 32'h2345_6789, 32'h1111_1111, 32'h1234_5678, 1'b0, 1'b0},
    '{1'b0, 1'b0, 32'h0F0F_0F0F, 32'h0101_0101, 32'h1010_1010, 1'b0, 1'b0},
    '{1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0},
    '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0001, 32'h0000_000E, 1'b0, 1'b0},
    '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0},
    '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1},
    '{1'b0, 1'b0, 32'h00FF_FF00, 32'h0001_0100, 32'h0101_0000, 1'b0, 1'b0}
  };

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sub = 1'b0, cin = 1'b0;
  logic         out_ready = 1'b1;
  logic [M-1:0] x = '0, y = '0;
`ifdef PIPE_ADD_SUB_SAT_EN
  logic         sat = 1'b0;
`endif
  logic         in_ready, out_valid, cout, v;
  logic [M-1:0] out;
  logic         in_ready_s1, out_valid_s1, cout_s1, v_s1;
  logic [M-1:0] out_s1;
  int           n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  pipe_cla_add_sub #(.M(M), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sub(sub), .cin(cin),
`ifdef PIPE_ADD_SUB_SAT_EN
    .sat(sat),
`endif
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cout(cout), .v(v)
  );

  pipe_cla_add_sub #(.M(M), .STAGES(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s1),
    .sub(sub), .cin(cin),
`ifdef PIPE_ADD_SUB_SAT_EN
    .sat(sat),
`endif
    .x(x), .y(y), .out_valid(out_valid_s1), .out_ready(out_ready),
    .out(out_s1), .cout(cout_s1), .v(v_s1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t t);
    in_valid = 1'b1; sub = t.sub; cin = t.cin; x = t.x; y = t.y;
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if (out_valid !== 1'b0 || out !== 32'h0 || cout !== 1'b0 || v !== 1'b0)
      $display("FAIL reset_outs: valid=%b out=%h cout=%b v=%b, want 0/0/0/0", out_valid, out, cout, v);
    else n_pass++;
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    n_chk++;
    if (out_valid_s1 !== 1'b0 || out_s1 !== 32'h0)
      $display("FAIL reset_s1: valid=%b out=%h want 0/0", out_valid_s1, out_s1);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_chunk_carry();
    in_valid = 1'b1; sub = 1'b0; cin = 1'b0; x = 32'h0000_FFFF; y = 32'h0000_0001;
    step();
    in_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      n_chk++;
      if (out_valid !== 1'b0) $display("FAIL lat_early cyc %0d: out_valid=%b want 0", c, out_valid);
      else n_pass++;
      step();
    end
    n_chk++;
    if (out_valid !== 1'b1 || out !== 32'h0001_0000 || cout !== 1'b0 || v !== 1'b0)
      $display("FAIL chunk_carry: valid=%b out=%h cout=%b v=%b want 1/00010000/0/0", out_valid, out, cout, v);
    else n_pass++;
    step();
    n_chk++;
    if (out_valid !== 1'b0 || out !== 32'h0001_0000)
      $display("FAIL bubble_hold: valid=%b out=%h want 0/00010000", out_valid, out);
    else n_pass++;
  endtask

  task automatic test_sub_ovf();
    drive(vt[4]); step();
    drive(vt[5]); step();
    in_valid = 1'b0;
    step(); step();
    n_chk++;
    if (out_valid !== 1'b1 || out !== 32'hFFFF_FFFF || cout !== 1'b1 || v !== 1'b0)
      $display("FAIL sub_borrow: valid=%b out=%h cout=%b v=%b want 1/ffffffff/1/0", out_valid, out, cout, v);
    else n_pass++;
    step();
    n_chk++;
    if (out_valid !== 1'b1 || out !== 32'h8000_0000 || cout !== 1'b0 || v !== 1'b1)
      $display("FAIL add_ovf: valid=%b out=%h cout=%b v=%b want 1/80000000/0/1", out_valid, out, cout, v);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      if (i < 16) drive(vt[i]);
      else in_valid = 1'b0;
      step();
      if (i >= 3 && i < 19) begin
        n_chk++;
        if (out_valid !== 1'b1 || out !== vt[i-3].r || cout !== vt[i-3].co || v !== vt[i-3].ov)
          $display("FAIL b2b[%0d]: valid=%b out=%h cout=%b v=%b want 1/%h/%b/%b",
                   i-3, out_valid, out, cout, v, vt[i-3].r, vt[i-3].co, vt[i-3].ov);
        else n_pass++;
      end else begin
        n_chk++;
        if (out_valid !== 1'b0) $display("FAIL b2b_idle cyc %0d: out_valid=%b want 0", i, out_valid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(vt[8+i]);
      step();
    end
    drive(vt[12]);
    for (int c = 0; c < 10; c++) begin
      n_chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== vt[8].r || cout !== vt[8].co)
        $display("FAIL bp_hold cyc %0d: in_ready=%b valid=%b out=%h want 0/1/%h", c, in_ready, out_valid, out, vt[8].r);
      else n_pass++;
      step();
    end
    out_ready = 1'b1;
    #1;
    for (int r = 0; r < 5; r++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out !== vt[8+r].r)
        $display("FAIL bp_drain[%0d]: valid=%b out=%h want 1/%h", r, out_valid, out, vt[8+r].r);
      else n_pass++;
      step();
      if (r == 0) in_valid = 1'b0;
    end
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL bp_dup: out_valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      drive(vt[i+1]);
      step();
    end
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || out !== vt[1].r)
      $display("FAIL pre_reset: valid=%b out=%h want 1/%h", out_valid, out, vt[1].r);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out !== 32'h0 || cout !== 1'b0 || v !== 1'b0)
      $display("FAIL mid_reset: valid=%b out=%h cout=%b v=%b want 0/0/0/0", out_valid, out, cout, v);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_chk++;
      if (out_valid !== 1'b0) $display("FAIL post_reset_ghost cyc %0d: out_valid=%b want 0", c, out_valid);
      else n_pass++;
    end
    drive(vt[8]);
    step();
    in_valid = 1'b0;
    step(); step(); step();
    n_chk++;
    if (out_valid !== 1'b1 || out !== vt[8].r)
      $display("FAIL post_reset_new: valid=%b out=%h want 1/%h", out_valid, out, vt[8].r);
    else n_pass++;
    step();
  endtask

  task automatic test_stages1();
    drive(vt[5]);
    step();
    n_chk++;
    if (out_valid_s1 !== 1'b1 || out_s1 !== 32'h8000_0000 || v_s1 !== 1'b1 || cout_s1 !== 1'b0)
      $display("FAIL s1_ovf: valid=%b out=%h cout=%b v=%b want 1/80000000/0/1", out_valid_s1, out_s1, cout_s1, v_s1);
    else n_pass++;
    drive(vt[4]);
    step();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid_s1 !== 1'b1 || out_s1 !== 32'hFFFF_FFFF || cout_s1 !== 1'b1 || v_s1 !== 1'b0)
      $display("FAIL s1_borrow: valid=%b out=%h cout=%b v=%b want 1/ffffffff/1/0", out_valid_s1, out_s1, cout_s1, v_s1);
    else n_pass++;
    step();
    n_chk++;
    if (out_valid_s1 !== 1'b0 || out_s1 !== 32'hFFFF_FFFF)
      $display("FAIL s1_bubble: valid=%b out=%h want 0/ffffffff", out_valid_s1, out_s1);
    else n_pass++;
    step(); step(); step();
  endtask

  task automatic test_sat();
    logic [31:0] exp1, exp2;
`ifdef PIPE_ADD_SUB_SAT_EN
    sat = 1'b1;
    exp1 = 32'h7FFF_FFFF;
    exp2 = 32'h8000_0000;
`else
    exp1 = 32'h8000_0004;
    exp2 = 32'h7FFF_FFFF;
`endif
    in_valid = 1'b1; sub = 1'b0; cin = 1'b0; x = 32'h7FFF_FFFF; y = 32'h0000_0005;
    step();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid_s1 !== 1'b1 || out_s1 !== exp1 || v_s1 !== 1'b1)
      $display("FAIL sat_pos_s1: valid=%b out=%h v=%b want 1/%h/1", out_valid_s1, out_s1, v_s1, exp1);
    else n_pass++;
    step(); step(); step();
    n_chk++;
    if (out_valid !== 1'b1 || out !== exp1 || v !== 1'b1)
      $display("FAIL sat_pos: valid=%b out=%h v=%b want 1/%h/1", out_valid, out, v, exp1);
    else n_pass++;
    in_valid = 1'b1; sub = 1'b1; cin = 1'b0; x = 32'h8000_0000; y = 32'h0000_0001;
    step();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid_s1 !== 1'b1 || out_s1 !== exp2 || v_s1 !== 1'b1)
      $display("FAIL sat_neg_s1: valid=%b out=%h v=%b want 1/%h/1", out_valid_s1, out_s1, v_s1, exp2);
    else n_pass++;
    step(); step(); step();
    n_chk++;
    if (out_valid !== 1'b1 || out !== exp2 || v !== 1'b1)
      $display("FAIL sat_neg: valid=%b out=%h v=%b want 1/%h/1", out_valid, out, v, exp2);
    else n_pass++;
    // No overflow: saturation flag must not disturb a normal sum.
    in_valid = 1'b1; sub = 1'b0; cin = 1'b0; x = 32'h0000_0001; y = 32'h0000_0002;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    n_chk++;
    if (out_valid !== 1'b1 || out !== 32'h0000_0003 || v !== 1'b0)
      $display("FAIL sat_noovf: valid=%b out=%h v=%b want 1/00000003/0", out_valid, out, v);
    else n_pass++;
`ifdef PIPE_ADD_SUB_SAT_EN
    sat = 1'b0;
`endif
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_chunk_carry();
    test_sub_ovf();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_stages1();
    test_sat();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
